// File: rtl/time_alarm_bank_57_if.sv
// Key/time inputs and edit/alarm outputs of the alarm bank, grouped as one bus.
interface time_alarm_bank_57_if #(
    parameter int unsigned N_ALARM = 4
);
    localparam int unsigned SLOT_W = $clog2(N_ALARM);

    logic              alarm_e_57;
    logic              key_slot_57;
    logic              key_select_57;
    logic              key_add_57;
    logic              key_sub_57;
    logic              key_confirm_57;
    logic [6:0]        cur_sec_57;
    logic [6:0]        cur_min_57;
    logic [6:0]        cur_hour_57;
    logic [SLOT_W-1:0] slot_57;
    logic [2:0]        select_57;
    logic [6:0]        sec_57;
    logic [6:0]        min_57;
    logic [6:0]        hour_57;
    logic              write_clock_e_57;
    logic [N_ALARM-1:0] armed_57;
    logic [N_ALARM-1:0] alarm_hit_57;

    modport master (
        output alarm_e_57, key_slot_57, key_select_57, key_add_57, key_sub_57,
               key_confirm_57, cur_sec_57, cur_min_57, cur_hour_57,
        input  slot_57, select_57, sec_57, min_57, hour_57, write_clock_e_57,
               armed_57, alarm_hit_57
    );

    modport slave (
        input  alarm_e_57, key_slot_57, key_select_57, key_add_57, key_sub_57,
               key_confirm_57, cur_sec_57, cur_min_57, cur_hour_57,
        output slot_57, select_57, sec_57, min_57, hour_57, write_clock_e_57,
               armed_57, alarm_hit_57
    );
endinterface

// File: rtl/time_alarm_bank_57.sv
// Multi-slot alarm editor/store with per-slot match pulses.
// Optional add/sub auto-repeat is enabled by defining ALARM_AUTOREPEAT_EN.
module time_alarm_bank_57 #(
    parameter int unsigned N_ALARM    = 4,
    parameter int unsigned REPEAT_DLY = 25_000_000,
    parameter int unsigned REPEAT_PER = 5_000_000
) (
    input  logic                 clk_50m_57,
    input  logic                 rst_57,
    time_alarm_bank_57_if.slave  bus
);
    localparam int unsigned SLOT_W = $clog2(N_ALARM);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EDIT   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam logic [6:0] SEC_MAX  = 7'd59;
    localparam logic [6:0] HOUR_MAX = 7'd23;

    logic [1:0]        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d, slot_nxt_c;
    logic [2:0]        select_q, select_d;
    logic [6:0]        sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic              wce_q;

    logic [6:0]        st_sec  [N_ALARM];
    logic [6:0]        st_min  [N_ALARM];
    logic [6:0]        st_hour [N_ALARM];
    logic [N_ALARM-1:0] armed_q, hit_q, hit_d;

    // Key history; ae_ok masks an alarm_e level already high when reset ends.
    logic       ae_q, ae_ok_q;
    logic [4:0] key_q;
    logic [6:0] cur_sec_q;

    logic ae_rise_c, slot_p_c, select_p_c, add_p_c, sub_p_c, confirm_p_c;
    logic add_act_c, sub_act_c, sec_chg_c;

    assign ae_rise_c   = bus.alarm_e_57 & ~ae_q & ae_ok_q;
    assign slot_p_c    = bus.key_slot_57    & ~key_q[0];
    assign select_p_c  = bus.key_select_57  & ~key_q[1];
    assign add_p_c     = bus.key_add_57     & ~key_q[2];
    assign sub_p_c     = bus.key_sub_57     & ~key_q[3];
    assign confirm_p_c = bus.key_confirm_57 & ~key_q[4];
    assign sec_chg_c   = bus.cur_sec_57 != cur_sec_q;

    assign slot_nxt_c = (slot_q == SLOT_W'(N_ALARM - 1)) ? '0 : slot_q + SLOT_W'(1);

    function automatic logic [6:0] step_field(input logic [6:0] v, input logic up,
                                              input logic [6:0] vmax);
        logic [6:0] r;
        if (up) r = (v >= vmax) ? 7'd0 : v + 7'd1;
        else    r = (v == 7'd0 || v > vmax) ? vmax : v - 7'd1;
        return r;
    endfunction

    always_ff @(posedge clk_50m_57 or negedge rst_57) begin
        if (!rst_57) begin
            ae_q      <= 1'b0;
            ae_ok_q   <= 1'b0;
            key_q     <= '0;
            cur_sec_q <= '0;
        end else begin
            ae_q      <= bus.alarm_e_57;
            ae_ok_q   <= 1'b1;
            key_q     <= {bus.key_confirm_57, bus.key_sub_57, bus.key_add_57,
                          bus.key_select_57, bus.key_slot_57};
            cur_sec_q <= bus.cur_sec_57;
        end
    end

`ifdef ALARM_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned CNT_W   = $clog2(RPT_MAX + 1);

    logic [CNT_W-1:0] hold_cnt_q;
    logic             hold_phase_q;
    logic             hold_c, press_c, rep_tick_c;

    // Hold is broken by release, both keys, leaving EDIT, or a field/slot change.
    assign hold_c  = (state_q == EDIT) && bus.alarm_e_57 &&
                     (bus.key_add_57 ^ bus.key_sub_57) &&
                     !confirm_p_c && !slot_p_c && !select_p_c;
    assign press_c = add_p_c | sub_p_c;
    assign rep_tick_c = hold_c && !press_c &&
                        ((!hold_phase_q && hold_cnt_q == CNT_W'(REPEAT_DLY)) ||
                         ( hold_phase_q && hold_cnt_q == CNT_W'(REPEAT_PER)));

    always_ff @(posedge clk_50m_57 or negedge rst_57) begin
        if (!rst_57) begin
            hold_cnt_q   <= '0;
            hold_phase_q <= 1'b0;
        end else if (!hold_c) begin
            hold_cnt_q   <= '0;
            hold_phase_q <= 1'b0;
        end else if (press_c) begin
            hold_cnt_q   <= CNT_W'(1);
            hold_phase_q <= 1'b0;
        end else if (rep_tick_c) begin
            hold_cnt_q   <= CNT_W'(1);
            hold_phase_q <= 1'b1;
        end else begin
            hold_cnt_q   <= hold_cnt_q + CNT_W'(1);
        end
    end

    assign add_act_c = add_p_c | (rep_tick_c & bus.key_add_57);
    assign sub_act_c = sub_p_c | (rep_tick_c & bus.key_sub_57);
`else
    assign add_act_c = add_p_c;
    assign sub_act_c = sub_p_c;
`endif

    // Next-state and edit-buffer logic; one key action per cycle.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        select_d = select_q;
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        case (state_q)
            IDLE: begin
                if (ae_rise_c) begin
                    state_d  = EDIT;
                    select_d = 3'b001;
                    sec_d    = st_sec[slot_q];
                    min_d    = st_min[slot_q];
                    hour_d   = st_hour[slot_q];
                end
            end
            EDIT: begin
                if (!bus.alarm_e_57) begin
                    state_d = IDLE;
                end else if (confirm_p_c) begin
                    state_d = COMMIT;
                end else if (slot_p_c) begin
                    slot_d   = slot_nxt_c;
                    select_d = 3'b001;
                    sec_d    = st_sec[slot_nxt_c];
                    min_d    = st_min[slot_nxt_c];
                    hour_d   = st_hour[slot_nxt_c];
                end else if (select_p_c) begin
                    select_d = {select_q[1:0], select_q[2]};
                end else if (add_act_c ^ sub_act_c) begin
                    case (select_q)
                        3'b001:  sec_d  = step_field(sec_q,  add_act_c, SEC_MAX);
                        3'b010:  min_d  = step_field(min_q,  add_act_c, SEC_MAX);
                        3'b100:  hour_d = step_field(hour_q, add_act_c, HOUR_MAX);
                        default: select_d = 3'b001;
                    endcase
                end
            end
            COMMIT: begin
                state_d = bus.alarm_e_57 ? EDIT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50m_57 or negedge rst_57) begin
        if (!rst_57) begin
            state_q  <= IDLE;
            slot_q   <= '0;
            select_q <= 3'b001;
            sec_q    <= '0;
            min_q    <= '0;
            hour_q   <= '0;
            wce_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            select_q <= select_d;
            sec_q    <= sec_d;
            min_q    <= min_d;
            hour_q   <= hour_d;
            wce_q    <= (state_d == COMMIT);
        end
    end

    // Slot store is written on the cycle the FSM sits in COMMIT.
    always_ff @(posedge clk_50m_57 or negedge rst_57) begin
        if (!rst_57) begin
            for (int i = 0; i < int'(N_ALARM); i++) begin
                st_sec[i]  <= '0;
                st_min[i]  <= '0;
                st_hour[i] <= '0;
            end
            armed_q <= '0;
        end else if (state_q == COMMIT) begin
            st_sec[slot_q]  <= sec_q;
            st_min[slot_q]  <= min_q;
            st_hour[slot_q] <= hour_q;
            armed_q[slot_q] <= 1'b1;
        end
    end

    // Match only on a fresh second so a commit at the current time stays silent.
    always_comb begin
        hit_d = '0;
        for (int i = 0; i < int'(N_ALARM); i++) begin
            hit_d[i] = armed_q[i] && sec_chg_c &&
                       bus.cur_sec_57  == st_sec[i] &&
                       bus.cur_min_57  == st_min[i] &&
                       bus.cur_hour_57 == st_hour[i];
        end
    end

    always_ff @(posedge clk_50m_57 or negedge rst_57) begin
        if (!rst_57) hit_q <= '0;
        else         hit_q <= hit_d;
    end

    assign bus.slot_57          = slot_q;
    assign bus.select_57        = select_q;
    assign bus.sec_57           = sec_q;
    assign bus.min_57           = min_q;
    assign bus.hour_57          = hour_q;
    assign bus.write_clock_e_57 = wce_q;
    assign bus.armed_57         = armed_q;
    assign bus.alarm_hit_57     = hit_q;
endmodule

// File: tb/tb_time_alarm_bank_57.sv
// Directed bench for time_alarm_bank_57: edit, wrap, commit, match and reset cases.
module tb_time_alarm_bank_57;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #10 clk = ~clk;

    time_alarm_bank_57_if #(.N_ALARM(4)) bus ();

    time_alarm_bank_57 #(
        .N_ALARM(4), .REPEAT_DLY(10), .REPEAT_PER(3)
    ) dut (
        .clk_50m_57(clk),
        .rst_57(rst_n),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // 0 slot, 1 select, 2 add, 3 sub, 4 confirm
    task automatic press(input int k);
        case (k)
            0: bus.key_slot_57 = 1'b1;
            1: bus.key_select_57 = 1'b1;
            2: bus.key_add_57 = 1'b1;
            3: bus.key_sub_57 = 1'b1;
            default: bus.key_confirm_57 = 1'b1;
        endcase
        tick(1);
        bus.key_slot_57 = 1'b0; bus.key_select_57 = 1'b0; bus.key_add_57 = 1'b0;
        bus.key_sub_57 = 1'b0; bus.key_confirm_57 = 1'b0;
        tick(1);
    endtask

    task automatic set_cur(input logic [6:0] h, input logic [6:0] m, input logic [6:0] s);
        bus.cur_hour_57 = h; bus.cur_min_57 = m; bus.cur_sec_57 = s;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_slot"},   32'(bus.slot_57), 0);
        check({tag, "_select"}, 32'(bus.select_57), 1);
        check({tag, "_sec"},    32'(bus.sec_57), 0);
        check({tag, "_min"},    32'(bus.min_57), 0);
        check({tag, "_hour"},   32'(bus.hour_57), 0);
        check({tag, "_wce"},    32'(bus.write_clock_e_57), 0);
        check({tag, "_armed"},  32'(bus.armed_57), 0);
        check({tag, "_hit"},    32'(bus.alarm_hit_57), 0);
    endtask

    initial begin
        bus.alarm_e_57 = 1'b1;
        bus.key_slot_57 = 1'b0; bus.key_select_57 = 1'b0; bus.key_add_57 = 1'b0;
        bus.key_sub_57 = 1'b0; bus.key_confirm_57 = 1'b0;
        set_cur(7'd0, 7'd0, 7'd0);

        // Reset with alarm_e already high; must stay IDLE afterwards
        tick(2);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick(3);
        press(2);
        check("idle_after_rst_sec", 32'(bus.sec_57), 0);

        // Fresh alarm_e rise, select hour, sub -> 23
        bus.alarm_e_57 = 1'b0; tick(1);
        bus.alarm_e_57 = 1'b1; tick(1);
        press(1); press(1);
        check("select_hour", 32'(bus.select_57), 4);
        press(3);
        check("hour_wrap_down", 32'(bus.hour_57), 23);
        check("hour_sub_min", 32'(bus.min_57), 0);
        check("hour_sub_sec", 32'(bus.sec_57), 0);

        // Seconds wrap both ways; add+sub together is a no-op
        press(1);
        check("select_sec", 32'(bus.select_57), 1);
        press(3);
        check("sec_wrap_down", 32'(bus.sec_57), 59);
        press(2);
        check("sec_wrap_up", 32'(bus.sec_57), 0);
        check("sec_wrap_min", 32'(bus.min_57), 0);
        bus.key_add_57 = 1'b1; bus.key_sub_57 = 1'b1; tick(1);
        bus.key_add_57 = 1'b0; bus.key_sub_57 = 1'b0; tick(1);
        check("add_sub_same", 32'(bus.sec_57), 0);
        press(1);
        press(3);
        check("min_wrap_down", 32'(bus.min_57), 59);

        // Slot 2 set to 07:30:00 and committed
        press(0); press(0);
        check("slot2", 32'(bus.slot_57), 2);
        check("slot2_reload_min", 32'(bus.min_57), 0);
        check("slot2_select", 32'(bus.select_57), 1);
        press(1); press(1);
        for (int i = 0; i < 7; i++) press(2);
        press(1); press(1);
        for (int i = 0; i < 30; i++) press(2);
        check("set_hour", 32'(bus.hour_57), 7);
        check("set_min", 32'(bus.min_57), 30);
        check("set_sec", 32'(bus.sec_57), 0);
        bus.key_confirm_57 = 1'b1; tick(1);
        check("commit_wce_hi", 32'(bus.write_clock_e_57), 1);
        bus.key_confirm_57 = 1'b0; tick(1);
        check("commit_wce_lo", 32'(bus.write_clock_e_57), 0);
        check("commit_armed", 32'(bus.armed_57), 4);

        // Time steps onto the alarm
        set_cur(7'd7, 7'd29, 7'd59); tick(1);
        check("hit_before", 32'(bus.alarm_hit_57), 0);
        set_cur(7'd7, 7'd30, 7'd0); tick(1);
        check("hit_pulse", 32'(bus.alarm_hit_57), 4);
        tick(1);
        check("hit_one_cycle", 32'(bus.alarm_hit_57), 0);

        // Re-commit at the current time raises no hit
        press(4);
        check("recommit_hit0", 32'(bus.alarm_hit_57), 0);
        tick(1);
        check("recommit_hit1", 32'(bus.alarm_hit_57), 0);
        check("recommit_armed", 32'(bus.armed_57), 4);

        // Uncommitted edit of slot 1 is discarded
        press(0); press(0); press(0);
        check("slot1", 32'(bus.slot_57), 1);
        press(1); press(1);
        for (int i = 0; i < 12; i++) press(2);
        check("slot1_hour12", 32'(bus.hour_57), 12);
        bus.alarm_e_57 = 1'b0; tick(2);
        bus.alarm_e_57 = 1'b1; tick(1);
        for (int i = 0; i < 4; i++) press(0);
        check("discard_slot", 32'(bus.slot_57), 1);
        check("discard_hour", 32'(bus.hour_57), 0);
        check("discard_min", 32'(bus.min_57), 0);
        check("discard_sec", 32'(bus.sec_57), 0);
        check("discard_armed", 32'(bus.armed_57), 4);

        // Hold add for 20 cycles on minutes
        press(1);
        check("select_min", 32'(bus.select_57), 2);
        bus.key_add_57 = 1'b1; tick(20);
        bus.key_add_57 = 1'b0; tick(1);
`ifdef ALARM_AUTOREPEAT_EN
        check("hold_add_min", 32'(bus.min_57), 5);
`else
        check("hold_add_min", 32'(bus.min_57), 1);
`endif

        // Reset asserted mid-COMMIT
        bus.key_confirm_57 = 1'b1; tick(1);
        check("commit2_wce_hi", 32'(bus.write_clock_e_57), 1);
        bus.key_confirm_57 = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_commit");
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check("post_rst_armed", 32'(bus.armed_57), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/time_alarm_bank_57.md
TIME_ALARM_BANK_57 -- requirements
Module: time_alarm_bank_57

Interface
REQ-001 SHALL have parameter N_ALARM, default 4, number of alarm slots (2..8).
REQ-002 SHALL have parameter REPEAT_DLY, default 25_000_000, hold cycles before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_PER, default 5_000_000, cycles between auto-repeat steps.
REQ-004 SHALL have port clk_50m_57  input  1  single 50 MHz clock, all logic on rising edge.
REQ-005 SHALL have port rst_57  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port alarm_e_57  input  1  alarm edit mode enable (level).
REQ-007 SHALL have ports key_slot_57, key_select_57, key_add_57, key_sub_57, key_confirm_57  input  1 each  debounced, clk-synchronous key levels.
REQ-008 SHALL have ports cur_sec_57, cur_min_57, cur_hour_57  input  7 each  running clock time.
REQ-009 SHALL have port slot_57  output  $clog2(N_ALARM)  slot being edited.
REQ-010 SHALL have port select_57  output  3  one-hot field: 001 sec, 010 min, 100 hour.
REQ-011 SHALL have ports sec_57, min_57, hour_57  output  7 each  edit buffer.
REQ-012 SHALL have port write_clock_e_57  output  1  one-cycle commit strobe.
REQ-013 SHALL have ports armed_57, alarm_hit_57  output  N_ALARM each  per-slot armed flag, one-cycle match pulse.

Function
REQ-014 SHALL detect key presses as rising edges (level high, previous-cycle low) on clk_50m_57; no logic SHALL be clocked by a key.
REQ-015 SHALL implement states IDLE, EDIT, COMMIT; IDLE->EDIT on alarm_e_57 rising, loading edit buffer from stored slot slot_57.
REQ-016 In EDIT, SHALL apply at most one key action per cycle, priority confirm > slot > select > add/sub.
REQ-017 key_select_57 press SHALL rotate select_57 001->010->100->001.
REQ-018 key_slot_57 press SHALL advance slot_57 modulo N_ALARM, reload edit buffer from new slot, reset select_57 to 001.
REQ-019 add press SHALL increment selected field with wrap 59->0 (sec/min), 23->0 (hour); sub SHALL decrement with wrap 0->59, 0->23.
REQ-020 add and sub pressed in the same cycle SHALL change nothing.
REQ-021 key_confirm_57 press SHALL enter COMMIT for exactly one cycle: store buffer to current slot, set its armed bit, assert write_clock_e_57, then return to EDIT.
REQ-022 alarm_e_57 low in EDIT or COMMIT SHALL return to IDLE next cycle, discarding uncommitted edits; a COMMIT in progress SHALL complete.
REQ-023 Edit buffer and stored slots SHALL never hold sec/min >59 or hour >23.
REQ-024 alarm_hit_57[i] SHALL pulse one cycle when armed_57[i]=1 and cur time newly equals slot i (cur_sec_57 differs from previous cycle), in any state.
REQ-025 Committing a slot whose value equals the current time SHALL NOT by itself raise alarm_hit_57.

Reset
REQ-026 On rst_57 low, asynchronously: state IDLE, slot_57=0, select_57=001, buffer 00:00:00, all slots 00:00:00, armed_57=0, alarm_hit_57=0, write_clock_e_57=0, key history=0.
REQ-027 After rst_57 rises with alarm_e_57 already high, SHALL stay IDLE until a fresh alarm_e_57 rising edge.

Configuration
REQ-028 Macro ALARM_AUTOREPEAT_EN defined: add/sub held high in EDIT SHALL give one step at press, one more after REPEAT_DLY cycles held, then one every REPEAT_PER cycles until released; release or field/slot change SHALL clear the hold counter.
REQ-029 Macro ALARM_AUTOREPEAT_EN undefined: add/sub SHALL act on press edges only; no hold counter SHALL be synthesised.

Verification
REQ-030 Reset, alarm_e rise, select to hour, sub once -> hour_57=23, min/sec=0.
REQ-031 Sec=59, add press -> sec_57=0, min_57 unchanged; add+sub same cycle -> no change.
REQ-032 Slot 2 set 07:30:00, confirm -> write_clock_e_57 one cycle, armed_57=0100; cur time steps 07:29:59->07:30:00 -> alarm_hit_57=0100 one cycle.
REQ-033 Edit slot 1 to 12:00:00, drop alarm_e without confirm, re-enter, slot to 1 -> buffer 00:00:00, armed_57[1]=0.
REQ-034 With ALARM_AUTOREPEAT_EN, REPEAT_DLY=10, REPEAT_PER=3, hold add 20 cycles on min=0 -> min_57=5; without macro -> min_57=1.
REQ-035 rst_57 low mid-COMMIT -> write_clock_e_57=0 immediately, armed_57=0, all outputs at reset values.
